// File: rtl/pak_link_fifo_pkg.sv
// rtl/pak_link_fifo_pkg.sv - shared link sizes and 4-phase channel FSM states
package pak_link_fifo_pkg;

    // Packet field widths used on every network link
    localparam int NS_ADDRESS_SIZE = 4;
    localparam int NS_DATA_SIZE    = 4;
    localparam int NS_REDUN_SIZE   = 4;
    localparam int NS_PACKET_SIZE  = NS_ADDRESS_SIZE + NS_DATA_SIZE + NS_REDUN_SIZE;

    // Receive side of a 4-phase channel
    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rcv_state_t;

    // Send side of a 4-phase channel
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } snd_state_t;

endpackage

// File: rtl/pak_fifo_mem.sv
// rtl/pak_fifo_mem.sv - DEPTH x PSZ packet store, sync write, async read
module pak_fifo_mem #(
    parameter int PSZ   = 12,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [PSZ-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [PSZ-1:0] rdata
);

    logic [PSZ-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; entries are only read after a write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pak_link_fifo.sv
// rtl/pak_link_fifo.sv - elastic 4-phase req/ack packet buffer for one link
module pak_link_fifo
    import pak_link_fifo_pkg::*;
#(
    parameter int ASZ   = NS_ADDRESS_SIZE,
    parameter int DSZ   = NS_DATA_SIZE,
    parameter int RSZ   = NS_REDUN_SIZE,
    parameter int PSZ   = ASZ + DSZ + RSZ,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic           i_clk,
    input  logic           reset,
    input  logic           rcv0_req,
    input  logic [PSZ-1:0] rcv0_data,
    output logic           rcv0_ack,
    output logic           snd0_req,
    output logic [PSZ-1:0] snd0_data,
    input  logic           snd0_ack,
    output logic [CW-1:0]  dbg_count,
    output logic           dbg_full,
    output logic           dbg_busy,
    output logic           has_err
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rcv_state_t     r_state, r_next;
    snd_state_t     s_state, s_next;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [PSZ-1:0] rd_data;
    logic [PSZ-1:0] rcv_data_q;
    logic           blocked_q;
    logic           full;
    logic           wr_en;
    logic           pop;
    logic           load;
    logic           blocked;
    logic           err_now;

    assign full    = (count == FULL_CNT);
    assign blocked = (r_state == R_IDLE) && rcv0_req && full;
    // A blocked sender must hold its packet; an ack with nothing offered is a sink fault
    assign err_now = (blocked && blocked_q && (rcv0_data != rcv_data_q))
                   || ((s_state == S_IDLE) && snd0_ack);

    pak_fifo_mem #(
        .PSZ   (PSZ),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rcv0_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // State registers for both channel FSMs
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            s_state <= S_IDLE;
        end else begin
            r_state <= r_next;
            s_state <= s_next;
        end
    end

    // Next-state logic; receive waits on free space, send waits on stored packets
    always_comb begin
        r_next = r_state;
        s_next = s_state;
        case (r_state)
            R_IDLE:  if (rcv0_req && !full) r_next = R_ACK;
            R_ACK:   if (!rcv0_req)         r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        case (s_state)
            S_IDLE:  if ((count != '0) && !snd0_ack) s_next = S_REQ;
            S_REQ:   if (snd0_ack)                   s_next = S_WAIT;
            S_WAIT:  if (!snd0_ack)                  s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // Per-state outputs and datapath strobes
    always_comb begin
        rcv0_ack = (r_state == R_ACK);
        snd0_req = (s_state == S_REQ);
        wr_en    = (r_state == R_IDLE) && rcv0_req && !full;
        load     = (s_state == S_IDLE) && (count != '0) && !snd0_ack;
        pop      = (s_state == S_REQ) && snd0_ack;
    end

    // Pointers, occupancy, output packet register and sticky error
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            snd0_data  <= '0;
            has_err    <= 1'b0;
            blocked_q  <= 1'b0;
            rcv_data_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load) begin
                snd0_data <= rd_data;
            end
            if (err_now) begin
                has_err <= 1'b1;
            end
            blocked_q  <= blocked;
            rcv_data_q <= rcv0_data;
        end
    end

    assign dbg_count = count;
    assign dbg_full  = full;
    assign dbg_busy  = (r_state != R_IDLE) || (s_state != S_IDLE);

endmodule

// File: tb/tb_pak_link_fifo.sv
// tb/tb_pak_link_fifo.sv - scoreboard bench for pak_link_fifo
module tb_pak_link_fifo;
    import pak_link_fifo_pkg::*;

    localparam int PSZ   = NS_PACKET_SIZE;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           i_clk = 1'b0;
    logic           reset = 1'b0;
    logic           rcv0_req = 1'b0;
    logic [PSZ-1:0] rcv0_data = '0;
    logic           rcv0_ack;
    logic           snd0_req;
    logic [PSZ-1:0] snd0_data;
    logic           snd0_ack = 1'b0;
    logic [CW-1:0]  dbg_count;
    logic           dbg_full;
    logic           dbg_busy;
    logic           has_err;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_total = 0;
    logic [PSZ-1:0] exp_q [$];

    bit sink_en   = 1'b0;
    bit sink_rand = 1'b0;
    bit force_ack = 1'b0;
    int wait_cnt  = 0;

    pak_link_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .rcv0_req  (rcv0_req),
        .rcv0_data (rcv0_data),
        .rcv0_ack  (rcv0_ack),
        .snd0_req  (snd0_req),
        .snd0_data (snd0_data),
        .snd0_ack  (snd0_ack),
        .dbg_count (dbg_count),
        .dbg_full  (dbg_full),
        .dbg_busy  (dbg_busy),
        .has_err   (has_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ack(input logic level, output int lat);
        lat = 0;
        while (rcv0_ack !== level && lat < 200) begin
            tick();
            lat++;
        end
        if (rcv0_ack !== level) chk("rcv0_ack_timeout", 32'(rcv0_ack), 32'(level));
    endtask

    task automatic send_pkt(input logic [PSZ-1:0] d, input int dly, output int lat, output int cnt);
        int dummy;
        repeat (dly) tick();
        rcv0_data = d;
        rcv0_req  = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, lat);
        cnt = int'(dbg_count);
        rcv0_req = 1'b0;
        wait_ack(1'b0, dummy);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || dbg_count != 0) && n < 500) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        reset = 1'b1;
        tick();
    endtask

    // Sink: 4-phase receiver with optional random ack delay, or a forced ack level
    initial begin
        forever begin
            tick();
            if (!sink_en) begin
                snd0_ack = force_ack;
            end else if (snd0_ack) begin
                if (!snd0_req) snd0_ack = 1'b0;
            end else if (snd0_req) begin
                if (wait_cnt == 0) begin
                    snd0_ack = 1'b1;
                    wait_cnt = sink_rand ? int'($urandom_range(0, 3)) : 0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Monitor: each new output offer is compared against the oldest expected packet
    initial begin
        logic prev_req;
        logic [PSZ-1:0] e;
        prev_req = 1'b0;
        forever begin
            @(negedge i_clk);
            if (reset) begin
                chk("count_le_depth", 32'(dbg_count <= CW'(DEPTH)), 32'd1);
                if (snd0_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_snd0_req", 32'(snd0_req), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("snd0_data_order", 32'(snd0_data), 32'(e));
                        rx_total++;
                    end
                end
            end
            prev_req = snd0_req;
        end
    end

    initial begin
        int lat, cnt, rx0;
        bit seen;

        // Reset state
        do_reset();
        chk("reset_rcv0_ack", 32'(rcv0_ack), 0);
        chk("reset_snd0_req", 32'(snd0_req), 0);
        chk("reset_snd0_data", 32'(snd0_data), 0);
        chk("reset_count", 32'(dbg_count), 0);
        chk("reset_has_err", 32'(has_err), 0);
        chk("reset_busy", 32'(dbg_busy), 0);

        // 1. single packet, sink acks immediately
        sink_en = 1'b1;
        send_pkt(12'h0A5, 0, lat, cnt);
        chk("t1_ack_latency", 32'(lat), 1);
        chk("t1_count_after_write", 32'(cnt), 1);
        drain("t1_drain");
        chk("t1_count_final", 32'(dbg_count), 0);
        chk("t1_rx_total", 32'(rx_total), 1);
        chk("t1_has_err", 32'(has_err), 0);

        // 2. fill to full with the sink stalled, then release
        sink_en = 1'b0;
        for (int i = 1; i <= 4; i++) send_pkt(PSZ'(i), 0, lat, cnt);
        chk("t2_full", 32'(dbg_full), 1);
        chk("t2_count4", 32'(dbg_count), 4);
        rcv0_data = 12'h005;
        rcv0_req  = 1'b1;
        exp_q.push_back(12'h005);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (rcv0_ack) seen = 1'b1;
        end
        chk("t2_blocked_ack", 32'(seen), 0);
        sink_en = 1'b1;
        wait_ack(1'b1, lat);
        rcv0_req = 1'b0;
        wait_ack(1'b0, lat);
        drain("t2_drain");
        chk("t2_rx_total", 32'(rx_total), 6);
        chk("t2_has_err", 32'(has_err), 0);

        // 3. wrap-around with random source and sink delays
        sink_rand = 1'b1;
        rx0 = rx_total;
        for (int i = 0; i < 20; i++) send_pkt(PSZ'(12'h300 + i), int'($urandom_range(0, 3)), lat, cnt);
        drain("t3_drain");
        chk("t3_rx_count", 32'(rx_total - rx0), 20);
        sink_rand = 1'b0;

        // 4. pop while full with a pending write: count returns to 4, oldest goes first
        sink_en = 1'b0;
        for (int i = 1; i <= 4; i++) send_pkt(PSZ'(12'h440 + i), 0, lat, cnt);
        rcv0_data = 12'h445;
        rcv0_req  = 1'b1;
        exp_q.push_back(12'h445);
        tick();
        wait_cnt = 0;
        sink_en  = 1'b1;
        wait_ack(1'b1, lat);
        chk("t4_count_stays4", 32'(dbg_count), 4);
        sink_en = 1'b0;
        rcv0_req = 1'b0;
        wait_ack(1'b0, lat);
        repeat (3) tick();
        chk("t4_next_oldest", 32'(snd0_data), 32'h442);
        sink_en = 1'b1;
        drain("t4_drain");

        // 5. reset in the middle of an output handshake
        sink_en = 1'b0;
        for (int i = 1; i <= 3; i++) send_pkt(PSZ'(12'h550 + i), 0, lat, cnt);
        tick();
        chk("t5_pre_req", 32'(snd0_req), 1);
        chk("t5_pre_count", 32'(dbg_count), 3);
        @(posedge i_clk);
        #3 reset = 1'b0;
        #1;
        chk("t5_async_snd0_req", 32'(snd0_req), 0);
        chk("t5_async_snd0_data", 32'(snd0_data), 0);
        chk("t5_async_count", 32'(dbg_count), 0);
        chk("t5_async_rcv0_ack", 32'(rcv0_ack), 0);
        exp_q.delete();
        @(negedge i_clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (snd0_req) seen = 1'b1;
        end
        chk("t5_no_spurious_req", 32'(seen), 0);
        chk("t5_count_after", 32'(dbg_count), 0);

        // 6. ack with no offer sets a sticky error
        force_ack = 1'b1;
        repeat (2) tick();
        force_ack = 1'b0;
        repeat (2) tick();
        chk("t6_has_err_set", 32'(has_err), 1);
        repeat (5) tick();
        chk("t6_has_err_sticky", 32'(has_err), 1);
        do_reset();
        chk("t6_has_err_cleared", 32'(has_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
